// File: rtl/disp_pkg.sv
// Shared types and constants for the display-source scheduler.
// The state enum doubles as the src output encoding.
package disp_pkg;

   typedef enum logic [1:0] {
      StGreet = 2'd0,
      StIdle  = 2'd1,
      StLive  = 2'd2,
      StPlay  = 2'd3
   } disp_state_e;

   localparam logic [7:0]  BLANK_CODE_DEF  = 8'hFF;
   localparam int unsigned GREET_BEATS_DEF = 8;
   localparam int unsigned HOLD_BEATS_DEF  = 4;

   // Number of bits needed to hold the value max_cnt.
   function automatic int unsigned cnt_width(input int unsigned max_cnt);
      int unsigned w;
      w = 1;
      while ((max_cnt >> w) != 0) w++;
      return w;
   endfunction

   localparam int unsigned CNT_W = cnt_width((GREET_BEATS_DEF > HOLD_BEATS_DEF) ?
                                             GREET_BEATS_DEF : HOLD_BEATS_DEF);

endpackage

// File: rtl/beat_edge_cnt.sv
// Beat strobe rising-edge detector with a clearable up-counter and a
// terminal-count flag raised on the edge that reaches i_term.
module beat_edge_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_beat,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_hit
);

   logic             r_beat_q;
   logic [CNT_W-1:0] r_cnt;
   logic             w_be;

   assign w_be  = i_beat & ~r_beat_q;
   assign o_hit = w_be & i_en & ((r_cnt + CNT_W'(1)) == i_term);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_beat_q <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_beat_q <= i_beat;
         // Clear wins over a coincident beat edge.
         if (i_clr) begin
            r_cnt <= '0;
         end else if (w_be && i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/disp_src_sched.sv
// Display-source scheduler: greeting after reset, then live key > autoplay > blank.
// Define GREET_SKIP_EN to let a key press abort the greeting.
module disp_src_sched
   import disp_pkg::*;
#(
   parameter int unsigned GREET_BEATS = GREET_BEATS_DEF,
   parameter int unsigned HOLD_BEATS  = HOLD_BEATS_DEF,
   parameter logic [7:0]  BLANK_CODE  = BLANK_CODE_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_beat,
   input  logic [7:0] i_greet_data,
   input  logic [7:0] i_tone_data,
   input  logic       i_tone_valid,
   input  logic [7:0] i_play_data,
   input  logic       i_play_req,
   output logic       o_play_gnt,
   output logic [7:0] o_data,
   output logic [1:0] o_src,
   output logic       o_greet_done
);

   disp_state_e      r_state;
   logic [7:0]       r_tone;
   logic [7:0]       r_data;
   logic [1:0]       r_src;
   logic             r_play_gnt;
   logic             r_greet_done;

   logic             w_hit;
   logic             w_skip;
   logic             w_greet_exit;
   logic             w_live_exit;
   logic             w_cnt_en;
   logic             w_cnt_clr;
   logic [CNT_W-1:0] w_term;

`ifdef GREET_SKIP_EN
   assign w_skip = i_tone_valid;
`else
   assign w_skip = 1'b0;
`endif

   assign w_greet_exit = w_skip | w_hit;
   assign w_live_exit  = !i_tone_valid && ((HOLD_BEATS == 0) || w_hit);
   assign w_term       = (r_state == StGreet) ? CNT_W'(GREET_BEATS) : CNT_W'(HOLD_BEATS);

   // Count only greeting beats and post-release hold beats; clear on every exit.
   assign w_cnt_en  = (r_state == StGreet) || ((r_state == StLive) && !i_tone_valid);
   assign w_cnt_clr = ((r_state == StGreet) && w_greet_exit) ||
                      ((r_state == StLive) && (i_tone_valid || w_live_exit)) ||
                      (r_state == StIdle) || (r_state == StPlay);

   beat_edge_cnt #(
      .CNT_W (CNT_W)
   ) u_beat_edge_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_beat  (i_beat),
      .i_en    (w_cnt_en),
      .i_clr   (w_cnt_clr),
      .i_term  (w_term),
      .o_hit   (w_hit)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= StGreet;
         r_tone       <= BLANK_CODE;
         r_data       <= BLANK_CODE;
         r_src        <= StGreet;
         r_play_gnt   <= 1'b0;
         r_greet_done <= 1'b0;
      end else begin
         if (i_tone_valid) begin
            r_tone <= i_tone_data;
         end

         // Outputs follow the state as it was before this edge.
         r_src      <= r_state;
         r_play_gnt <= (r_state == StPlay);
         case (r_state)
            StGreet: r_data <= i_greet_data;
            StLive:  r_data <= r_tone;
            StPlay:  r_data <= i_play_data;
            default: r_data <= BLANK_CODE;
         endcase

         case (r_state)
            StGreet: begin
               if (w_skip) begin
                  r_state      <= StLive;
                  r_greet_done <= 1'b1;
               end else if (w_hit) begin
                  r_state      <= StIdle;
                  r_greet_done <= 1'b1;
               end
            end
            StIdle: begin
               if (i_tone_valid) begin
                  r_state <= StLive;
               end else if (i_play_req) begin
                  r_state <= StPlay;
               end
            end
            StLive: begin
               if (w_live_exit) begin
                  r_state <= StIdle;
               end
            end
            StPlay: begin
               if (i_tone_valid) begin
                  r_state <= StLive;
               end else if (!i_play_req) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_data       = r_data;
   assign o_src        = r_src;
   assign o_play_gnt   = r_play_gnt;
   assign o_greet_done = r_greet_done;

endmodule

// File: doc/disp_src_sched.md
Name: disp_src_sched

Overview:
Display-source scheduler for the piano's 8-bit display bus. It shares one display port between three producers: the boot greeting, live key tone, and song autoplay. After reset it shows the greeting for a fixed number of beats. It then grants the bus by priority (live key > autoplay > blank) and holds the last tone for a few beats after key release. All logic is in the clk domain; beat is edge-detected, not used as a clock.

Parameters:
GREET_BEATS, 8, beat rising edges the greeting is displayed after reset (must be >= 1)
HOLD_BEATS, 4, beat rising edges the last tone stays displayed after key release (0 allowed)
BLANK_CODE, 8'hFF, display value meaning "all segments off" (active-low segments)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
beat  input  1  beat strobe level, generated in clk domain; rising edge = one beat
greet_data  input  8  greeting pattern from greeting ROM
tone_data  input  8  tone code for the currently pressed key
tone_valid  input  1  high while any key is pressed
play_data  input  8  autoplay display value
play_req  input  1  autoplay requests the display
play_gnt  output  1  autoplay currently owns the display
data  output  8  display bus
src  output  2  current owner: 0 GREET, 1 IDLE, 2 LIVE, 3 PLAY
greet_done  output  1  sticky; high once greeting finished

Behaviour:
- Reset is synchronous: when rst_n is low at a clk edge, every register is reset. This applies mid-operation, including a greeting or hold in progress.
- Reset values: state GREET, beat counter 0, beat_q 0, tone latch BLANK_CODE, data BLANK_CODE, src 0, play_gnt 0, greet_done 0.
- Beat edge: be = beat & ~beat_q; beat_q <= beat every cycle. A beat held high counts once.
- Outputs are registered. data, src and play_gnt reflect the state of the previous cycle, so there is 1-cycle latency from a state change to the outputs.
- data mux by state: GREET uses greet_data, IDLE uses BLANK_CODE, LIVE uses the tone latch, PLAY uses play_data.
- Tone latch: loads tone_data every cycle that tone_valid=1, in any state. It holds otherwise.
- GREET:
  - Each be increments the counter.
  - On the be that makes the count equal GREET_BEATS, go to IDLE, set greet_done=1 and clear the counter.
  - tone_valid and play_req are ignored (see the optional feature).
- IDLE:
  - tone_valid=1 goes to LIVE.
  - Otherwise play_req=1 goes to PLAY.
  - Otherwise stay.
  - If both are high, LIVE wins.
- LIVE:
  - While tone_valid=1, the counter is held at 0.
  - While tone_valid=0, each be increments the counter. Reaching HOLD_BEATS goes to IDLE and clears the counter.
  - HOLD_BEATS=0 means leave on the first cycle with tone_valid=0.
  - tone_valid reasserting in the same cycle as be: the counter clears (reset beats count).
- PLAY:
  - tone_valid=1 preempts: go to LIVE, and play_gnt falls on the next output update.
  - play_req=0 with no key goes to IDLE.
  - play_req must stay high while it wants the bus; dropping it for one cycle releases the grant.
- Counter width: CNT_W from the package, wide enough for max(GREET_BEATS, HOLD_BEATS). It never wraps, because terminal counts always cause a transition.
- Illegal state encoding recovers to IDLE.

Optional Feature:
GREET_SKIP_EN
- Defined: tone_valid=1 during GREET aborts the greeting. The next state is LIVE, greet_done=1 and the counter clears.
- Undefined: keys are ignored during GREET, although the tone latch still loads.

Decomposition:
- Package disp_pkg holds:
  - the state enum (GREET=0, IDLE=1, LIVE=2, PLAY=3), shared with the src encoding
  - BLANK_CODE default
  - CNT_W
- One natural sub-module, beat_edge_cnt: rising-edge detect plus a clearable beat counter with a terminal-count flag, instantiated once.

Test Plan:
- Reset then 8 beat pulses, greet_data=8'h3C, no keys:
  - data=8'h3C, src=0 until the 8th edge.
  - One cycle later src=1, data=8'hFF, greet_done=1.
- After greeting, tone_valid=1 with tone_data=8'h21 for 10 cycles, then release; then 4 beats:
  - data=8'h21 throughout the hold.
  - After the 4th edge, src=1 and data=8'hFF.
- IDLE with play_req=1 and play_data=8'h55:
  - play_gnt=1, src=3, data=8'h55.
  - Assert tone_valid with tone_data=8'h12: next update gives play_gnt=0, src=2, data=8'h12.
- LIVE hold, after 3 beats a key re-pressed coincident with the 4th beat edge: stays LIVE and the hold count restarts (needs 4 more beats).
- rst_n low for one cycle during PLAY: next cycle data=8'hFF, src=0, play_gnt=0, greet_done=0, and the greeting restarts its full 8 beats.
- With GREET_SKIP_EN, tone_valid=1 at beat 3 of the greeting: src=2, greet_done=1, data shows the tone. Without the macro, src stays 0 until the 8th beat.
